// File: rtl/uart_core.sv
// uart_core: 16x-oversampled UART with runtime baud divisor, optional parity, sticky error flags and RX/TX FIFOs
module uart_core #(
    parameter int   DBIT       = 8,
    parameter int   SB_TICK    = 16,
    parameter int   DVSR_BIT   = 16,
    parameter int   FIFO_W     = 2,
    parameter logic PARITY_EN  = 1'b0,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DVSR_BIT-1:0] i_dvsr,
    input  logic                i_rx,
    input  logic                i_rd_uart,
    input  logic                i_wr_uart,
    input  logic [DBIT-1:0]     i_w_data,
    input  logic                i_clr_err,
    output logic                o_tx,
    output logic [DBIT-1:0]     o_r_data,
    output logic                o_rx_empty,
    output logic                o_tx_full,
    output logic                o_tx_empty,
    output logic                o_frame_err,
    output logic                o_parity_err,
    output logic                o_overrun
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);
    localparam int DEPTH = 1 << FIFO_W;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DVSR_BIT-1:0] cnt, dvsr_q;
    logic tick;
    logic [1:0] sync;
    logic rx_in;
    assign tick = cnt == dvsr_q;
    assign rx_in = sync[1];
    // divisor is latched at wrap so a new value never truncates the current period
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            cnt <= '0;
            dvsr_q <= '0;
            sync <= 2'b11;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) dvsr_q <= i_dvsr;
            sync <= {sync[0], i_rx};
        end

    state_t r_st, r_st_n, t_st, t_st_n;
    logic [4:0] r_s, r_s_n, t_s, t_s_n;
    logic [NW-1:0] r_n, r_n_n, t_n, t_n_n;
    logic [DBIT-1:0] r_b, r_b_n, t_sh, t_sh_n, t_dout;
    logic t_par, t_par_n, t_bit_n, push, pop, ferr_set, perr_set, t_empty;

    logic [DBIT-1:0] r_mem [DEPTH];
    logic [DBIT-1:0] t_mem [DEPTH];
    logic [FIFO_W-1:0] r_wp, r_rp, t_wp, t_rp;
    logic [FIFO_W:0] r_cnt, t_cnt;
    logic r_full, r_wr, r_rd, t_wr;
    assign o_rx_empty = r_cnt == '0;
    assign r_full = r_cnt[FIFO_W];
    assign r_wr = push && !r_full;
    assign r_rd = i_rd_uart && !o_rx_empty;
    assign o_r_data = r_mem[r_rp];
    assign t_empty = t_cnt == '0;
    assign o_tx_full = t_cnt[FIFO_W];
    assign t_wr = i_wr_uart && !o_tx_full;
    assign t_dout = t_mem[t_rp];
    assign o_tx_empty = t_empty && t_st == IDLE;

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
            t_wp <= '0;
            t_rp <= '0;
            t_cnt <= '0;
        end else begin
            r_wp <= r_wp + FIFO_W'(r_wr);
            r_rp <= r_rp + FIFO_W'(r_rd);
            r_cnt <= r_cnt + (FIFO_W+1)'(r_wr) - (FIFO_W+1)'(r_rd);
            t_wp <= t_wp + FIFO_W'(t_wr);
            t_rp <= t_rp + FIFO_W'(pop);
            t_cnt <= t_cnt + (FIFO_W+1)'(t_wr) - (FIFO_W+1)'(pop);
        end

    always_ff @(posedge i_clk) begin
        if (r_wr) r_mem[r_wp] <= r_b;
        if (t_wr) t_mem[t_wp] <= i_w_data;
    end

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            o_frame_err <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_frame_err <= ferr_set || (o_frame_err && !i_clr_err);
            o_parity_err <= perr_set || (o_parity_err && !i_clr_err);
            o_overrun <= (push && r_full) || (o_overrun && !i_clr_err);
        end

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            r_st <= IDLE;
            r_s <= '0;
            r_n <= '0;
            r_b <= '0;
            t_st <= IDLE;
            t_s <= '0;
            t_n <= '0;
            t_sh <= '0;
            t_par <= 1'b0;
            o_tx <= 1'b1;
        end else begin
            r_st <= r_st_n;
            r_s <= r_s_n;
            r_n <= r_n_n;
            r_b <= r_b_n;
            t_st <= t_st_n;
            t_s <= t_s_n;
            t_n <= t_n_n;
            t_sh <= t_sh_n;
            t_par <= t_par_n;
            o_tx <= t_bit_n;
        end

    always_comb begin
        r_st_n = r_st;
        r_s_n = r_s;
        r_n_n = r_n;
        r_b_n = r_b;
        push = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (r_st)
            IDLE: if (!rx_in) begin
                r_st_n = START;
                r_s_n = '0;
            end
            START: if (tick) begin
                if (r_s == 5'd7) begin
                    r_st_n = rx_in ? IDLE : DATA;
                    r_s_n = '0;
                    r_n_n = '0;
                end else r_s_n = r_s + 5'd1;
            end
            DATA: if (tick) begin
                if (r_s == 5'd15) begin
                    r_s_n = '0;
                    r_b_n = {rx_in, r_b[DBIT-1:1]};
                    r_n_n = r_n + 1'b1;
                    if (r_n == N_LAST) r_st_n = PARITY_EN ? PARITY : STOP;
                end else r_s_n = r_s + 5'd1;
            end
            PARITY: if (tick) begin
                if (r_s == 5'd15) begin
                    r_s_n = '0;
                    perr_set = rx_in != (^r_b ^ PARITY_ODD);
                    r_st_n = STOP;
                end else r_s_n = r_s + 5'd1;
            end
            STOP: if (tick) begin
                if (r_s == S_LAST) begin
                    r_st_n = IDLE;
                    push = rx_in;
                    ferr_set = !rx_in;
                end else r_s_n = r_s + 5'd1;
            end
            default: r_st_n = IDLE;
        endcase
    end

    // o_tx is registered from next-state values so it changes on the same edge as the FSM
    always_comb begin
        t_st_n = t_st;
        t_s_n = t_s;
        t_n_n = t_n;
        t_sh_n = t_sh;
        t_par_n = t_par;
        pop = 1'b0;
        case (t_st)
            IDLE: if (!t_empty) begin
                pop = 1'b1;
                t_sh_n = t_dout;
                t_par_n = ^t_dout ^ PARITY_ODD;
                t_st_n = START;
                t_s_n = '0;
            end
            START: if (tick) begin
                if (t_s == 5'd15) begin
                    t_st_n = DATA;
                    t_s_n = '0;
                    t_n_n = '0;
                end else t_s_n = t_s + 5'd1;
            end
            DATA: if (tick) begin
                if (t_s == 5'd15) begin
                    t_s_n = '0;
                    t_sh_n = t_sh >> 1;
                    t_n_n = t_n + 1'b1;
                    if (t_n == N_LAST) t_st_n = PARITY_EN ? PARITY : STOP;
                end else t_s_n = t_s + 5'd1;
            end
            PARITY: if (tick) begin
                if (t_s == 5'd15) begin
                    t_st_n = STOP;
                    t_s_n = '0;
                end else t_s_n = t_s + 5'd1;
            end
            STOP: if (tick) begin
                if (t_s == S_LAST) t_st_n = IDLE;
                else t_s_n = t_s + 5'd1;
            end
            default: t_st_n = IDLE;
        endcase
        t_bit_n = t_st_n == START ? 1'b0 : t_st_n == DATA ? t_sh_n[0] : t_st_n == PARITY ? t_par_n : 1'b1;
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of TX framing, loopback, FIFOs, error flags and reset
module tb_uart_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] dvsr = 16'd3;
    logic loop = 1'b0;
    logic rx_drv0 = 1'b1, rd0 = 1'b0, wr0 = 1'b0, clr0 = 1'b0;
    logic [7:0] wd0 = 8'h00;
    logic rx1 = 1'b1, rd1 = 1'b0, clr1 = 1'b0;
    logic rx0, tx0, rx_empty0, tx_full0, tx_empty0, ferr0, perr0, ovr0;
    logic tx1, rx_empty1, tx_full1, tx_empty1, ferr1, perr1, ovr1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] lb [6];
    logic [7:0] bits;
    int n_vec = 0, n_err = 0, len;

    always #5 clk = ~clk;
    assign rx0 = loop ? tx0 : rx_drv0;

    uart_core u0 (
        .i_clk(clk), .i_rst(rst_n), .i_dvsr(dvsr), .i_rx(rx0), .i_rd_uart(rd0),
        .i_wr_uart(wr0), .i_w_data(wd0), .i_clr_err(clr0), .o_tx(tx0), .o_r_data(rdata0),
        .o_rx_empty(rx_empty0), .o_tx_full(tx_full0), .o_tx_empty(tx_empty0),
        .o_frame_err(ferr0), .o_parity_err(perr0), .o_overrun(ovr0)
    );

    uart_core #(.PARITY_EN(1'b1)) u1 (
        .i_clk(clk), .i_rst(rst_n), .i_dvsr(dvsr), .i_rx(rx1), .i_rd_uart(rd1),
        .i_wr_uart(1'b0), .i_w_data(8'h00), .i_clr_err(clr1), .o_tx(tx1), .o_r_data(rdata1),
        .o_rx_empty(rx_empty1), .o_tx_full(tx_full1), .o_tx_empty(tx_empty1),
        .o_frame_err(ferr1), .o_parity_err(perr1), .o_overrun(ovr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input bit sel, input logic v);
        if (sel) rx1 = v;
        else rx_drv0 = v;
    endtask

    // one frame at 16 clocks per bit (divisor 0); par < 0 omits the parity bit
    task automatic send(input bit sel, input logic [7:0] d, input int par, input logic stop);
        put(sel, 1'b0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            put(sel, d[i]);
            repeat (16) @(negedge clk);
        end
        if (par >= 0) begin
            put(sel, par[0]);
            repeat (16) @(negedge clk);
        end
        put(sel, stop);
        repeat (16) @(negedge clk);
        put(sel, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic read0(input string tag, input logic [7:0] exp);
        check({tag, "_avail"}, rx_empty0, 0);
        check(tag, rdata0, exp);
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
    endtask

    task automatic pulse_clr(input bit sel);
        if (sel) clr1 = 1'b1;
        else clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        clr1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        lb = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'h99};
        repeat (3) @(negedge clk);
        check("rst_tx", tx0, 1);
        check("rst_rx_empty", rx_empty0, 1);
        check("rst_tx_full", tx_full0, 0);
        check("rst_tx_empty", tx_empty0, 1);
        check("rst_flags", {ferr0, perr0, ovr0}, 0);
        check("rst_u1", {tx1, rx_empty1, tx_full1, tx_empty1, ferr1, perr1, ovr1}, 7'b1101000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        wr0 = 1'b1;
        wd0 = 8'hA5;
        @(negedge clk);
        wr0 = 1'b0;
        check("tx_busy_empty", tx_empty0, 0);
        for (int k = 0; k < 20 && tx0; k++) @(negedge clk);
        check("tx_start_seen", tx0, 0);
        len = 0;
        while (!tx0 && len < 80) begin
            len++;
            @(negedge clk);
        end
        check("tx_start_len", len >= 61 && len <= 64, 1);
        bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_bit%0d_head", i), tx0, bits[i]);
            repeat (62) @(negedge clk);
            check($sformatf("tx_bit%0d_tail", i), tx0, bits[i]);
            repeat (2) @(negedge clk);
        end
        check("tx_stop_head", tx0, 1);
        repeat (62) @(negedge clk);
        check("tx_stop_tail", tx0, 1);
        check("tx_stop_busy", tx_empty0, 0);
        repeat (2) @(negedge clk);
        check("tx_done_empty", tx_empty0, 1);

        wr0 = 1'b1;
        wd0 = 8'h00;
        @(negedge clk);
        wr0 = 1'b0;
        for (int k = 0; k < 20 && tx0; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("pre_rst_tx", tx0, 0);
        #2 rst_n = 1'b0;
        #1 check("rst_async_tx", tx0, 1);
        @(negedge clk);
        check("midrst_status", {rx_empty0, tx_full0, tx_empty0}, 3'b101);
        check("midrst_flags", {ferr0, perr0, ovr0}, 0);
        rst_n = 1'b1;
        dvsr = 16'd0;
        repeat (10) @(negedge clk);
        check("postrst_idle", {tx0, tx_empty0}, 2'b11);

        loop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr0 = 1'b1;
            wd0 = lb[i];
            @(negedge clk);
            if (i == 3) check("txf_not_full", tx_full0, 0);
            if (i >= 4) check($sformatf("txf_full%0d", i), tx_full0, 1);
        end
        wr0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 400 && rx_empty0; k++) @(negedge clk);
            read0($sformatf("lb_data%0d", i), lb[i]);
        end
        repeat (300) @(negedge clk);
        check("lb_drop", rx_empty0, 1);
        check("lb_tx_done", tx_empty0, 1);
        check("lb_flags", {ferr0, perr0, ovr0}, 0);
        loop = 1'b0;
        repeat (5) @(negedge clk);

        send(0, 8'h42, -1, 1'b0);
        repeat (40) @(negedge clk);
        check("fe_flag", ferr0, 1);
        check("fe_empty", rx_empty0, 1);
        pulse_clr(0);
        check("fe_clr", ferr0, 0);

        for (int i = 0; i < 5; i++) begin
            send(0, 8'h10 + 8'(i), -1, 1'b1);
            if (i == 3) check("ovr_not_yet", ovr0, 0);
        end
        check("ovr_flag", ovr0, 1);
        for (int i = 0; i < 4; i++) read0($sformatf("ovr_data%0d", i), 8'h10 + 8'(i));
        check("ovr_drained", rx_empty0, 1);
        check("ovr_no_fe", ferr0, 0);
        pulse_clr(0);
        check("ovr_clr", ovr0, 0);

        rx_drv0 = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv0 = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_empty", rx_empty0, 1);
        check("glitch_flags", {ferr0, perr0, ovr0}, 0);
        send(0, 8'h5A, -1, 1'b1);
        read0("post_glitch", 8'h5A);

        send(1, 8'h07, 0, 1'b1);
        check("par_err", perr1, 1);
        check("par_avail", rx_empty1, 0);
        check("par_data", rdata1, 8'h07);
        rd1 = 1'b1;
        @(negedge clk);
        rd1 = 1'b0;
        pulse_clr(1);
        check("par_clr", perr1, 0);
        send(1, 8'h07, 1, 1'b1);
        check("par_ok", perr1, 0);
        check("par_ok_data", rdata1, 8'h07);
        check("par_ok_flags", {ferr1, ovr1, rx_empty1}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised UART core with a runtime-programmable baud divisor, optional parity, error detection, and FIFO buffering on both the receive and transmit paths. It combines four functions behind one byte-wide handshake interface: a 16x oversampling tick generator, an RX engine, a TX engine, and two FIFOs of 2^FIFO_W words each. It sits between the pins and the ALU/command interface logic, and supersedes the fixed-rate, unbuffered UART top level.

## Interface
- DBIT, 8, data bits per frame.
- SB_TICK, 16, oversampling ticks for the stop bit (16/24/32 = 1/1.5/2 stop bits).
- DVSR_BIT, 16, width of the divisor input.
- FIFO_W, 2, FIFO address bits; each FIFO holds 2^FIFO_W words.
- PARITY_EN, 0, 1 inserts and checks a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity; 0 selects even parity.

Ports:
- i_clk, in, 1, single clock; all state is on the rising edge.
- i_rst, in, 1, reset: asynchronous, active-low.
- i_dvsr, in, DVSR_BIT, tick period is i_dvsr+1 clocks; set it to clk/(16*baud)-1.
- i_rx, in, 1, serial input, asynchronous to i_clk.
- i_rd_uart, in, 1, pop the RX FIFO head.
- i_wr_uart, in, 1, push i_w_data into the TX FIFO.
- i_w_data, in, DBIT, TX write data.
- i_clr_err, in, 1, clears all sticky error flags.
- o_tx, out, 1, serial output.
- o_r_data, out, DBIT, RX FIFO head (first-word-fall-through).
- o_rx_empty, out, 1, RX FIFO empty.
- o_tx_full, out, 1, TX FIFO full.
- o_tx_empty, out, 1, TX FIFO empty and TX engine idle.
- o_frame_err, out, 1, sticky: a stop bit was sampled as 0.
- o_parity_err, out, 1, sticky: received parity did not match.
- o_overrun, out, 1, sticky: a received word was dropped because the RX FIFO was full.

## Operation
- **Tick generator:** free-running counter over 0..i_dvsr.
  - The one-cycle tick fires when count==i_dvsr, then the counter wraps to 0.
  - i_dvsr=0 produces a tick every clock.
  - A change to i_dvsr takes effect at the next wrap.
- **RX input:** i_rx passes through a 2-FF synchronizer, reset to 1. Tick counter s and bit counter n drive the RX FSM states IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronized rx==0 -> START, s=0.
  - START: at tick with s==7, rx==0 -> DATA (s=0, n=0). If rx==1 at that point, this is a false start -> IDLE, and nothing is recorded.
  - DATA: at tick with s==15, sample the bit and shift it in, LSB first. After n==DBIT-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: at s==15, compare the sample with the XOR of the data, inverted if PARITY_ODD. On mismatch, set o_parity_err.
  - STOP: at s==SB_TICK-1, sample the line, then -> IDLE.
    - Sample 0: set o_frame_err and discard the word.
    - Sample 1: push the word; a parity mismatch still pushes it.
    - RX FIFO full at push: drop the word and set o_overrun.
- **TX engine** (IDLE, START, DATA, PARITY, STOP):
  - IDLE with TX FIFO non-empty: pop the head into the shift register and go to START. o_tx=1 while IDLE.
  - START: o_tx=0 for 16 ticks.
  - DATA: each of the DBIT bits is held for 16 ticks, LSB first.
  - PARITY: if enabled, held for 16 ticks.
  - STOP: o_tx=1 for SB_TICK ticks, then -> IDLE. The next word may start immediately.
- **FIFOs:** circular buffers with wrap-around pointers and a count of 0..2^FIFO_W.
  - Write when full is ignored, even if a read occurs in the same cycle.
  - Read when empty is ignored. Read and write together on an empty FIFO: the write is accepted and the read is ignored.
  - Otherwise, simultaneous read and write both take effect and the count is unchanged.
  - o_r_data is valid only while o_rx_empty=0; its value is don't-care when empty.
- **Sticky flags:** held until i_clr_err. If i_clr_err coincides with a new error, the set wins.

## Timing
- Reset values:
  - o_tx=1, o_rx_empty=1, o_tx_full=0, o_tx_empty=1.
  - All error flags 0; both FSMs in IDLE; counters 0; FIFOs empty.
- Reset asserted mid-frame: o_tx goes to 1 immediately (asynchronously), and the in-flight frame and all FIFO contents are lost.
- Flags and FIFO status outputs are registered; each updates on the clock edge after its causing event.
- RX: o_rx_empty falls 1 cycle after the tick that samples the stop bit at s==SB_TICK-1, i.e. mid-stop-bit. Synchronizer latency is 2 cycles.
- TX: the pop occurs on the cycle after the TX FIFO becomes non-empty while the engine is IDLE. o_tx falls at the same edge the engine enters START.
- Start-bit length is 16 ticks, counted from the first tick after entering START. The leading partial tick period is up to i_dvsr+1 clocks.
- Frame length is (1+DBIT+PARITY_EN)*16+SB_TICK ticks.
- Example: 50 MHz, 115200 baud -> i_dvsr=26.

## Test plan
- **Reset:** assert i_rst=0 mid-transmission -> o_tx=1 within the same cycle; o_rx_empty=1, o_tx_empty=1, all flags 0.
- **TX frame:** i_dvsr=3, write 0xA5 -> o_tx low for 64 clocks, then bits 1,0,1,0,0,1,0,1 for 64 clocks each, then high for 64 clocks; o_tx_empty=1 afterwards.
- **Loopback and TX FIFO full:** o_tx tied to i_rx, i_dvsr=0, FIFO_W=2; write 0x00,0xFF,0x55,0x3C,0x81 back-to-back, then 0x99 -> o_tx_full=1 after the 5th write and 0x99 is dropped. Reading returns 0x00,0xFF,0x55,0x3C,0x81 in order.
- **Framing error:** drive a frame carrying 0x42 with stop bit 0 -> o_frame_err=1 and o_rx_empty stays 1. Pulse i_clr_err -> o_frame_err=0.
- **Parity:** PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 0 -> o_parity_err=1 and 0x07 appears at o_r_data. Send 0x07 with parity bit 1 -> no new error.
- **Overrun and false start:**
  - With no reads, send 5 frames 0x10..0x14 -> o_overrun=1; reads return 0x10..0x13.
  - A 3-tick low glitch on i_rx -> no word, no flag.
